// File: rtl/perceptron_bp.sv
// perceptron_bp -- single-table perceptron branch direction predictor.
//
// One prediction in flight at a time. A request in IDLE selects a perceptron
// and snapshots the global history. SUM walks the HIST_LEN+1 weights, one per
// cycle, then spends one extra cycle presenting the result on pred_valid.
// WAIT_UPD takes the resolved outcome and shifts it into the history. TRAIN
// then adjusts the same perceptron, one weight per cycle, if the prediction
// was wrong or weak. After reset, CLEAR zeroes the table one perceptron per
// cycle.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   req_valid/req_ready     prediction request handshake (IDLE only)
//   req_addr[ADDR_W]        branch address; the index is (addr>>2) mod NUM_PERC
//   pred_valid              one-cycle pulse HIST_LEN+2 cycles after accept
//   pred_taken, pred_conf   direction and |sum| > THETA, held until next pulse
//   upd_valid/upd_ready     outcome handshake (WAIT_UPD only)
//   upd_taken               resolved direction
//   busy                    FSM is not in IDLE
//   hist[HIST_LEN]          global history, bit 0 newest
//
// Build option: BP_HIST_HASH_EN -- when defined, the history is XORed into
// the index: ((addr>>2) ^ hist) mod NUM_PERC.
module perceptron_bp #(
  parameter int ADDR_W   = 8,
  parameter int HIST_LEN = 7,
  parameter int WEIGHT_W = 8,
  parameter int NUM_PERC = 12,
  parameter int THETA    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic                pred_conf,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic                upd_taken,
  output logic                busy,
  output logic [HIST_LEN-1:0] hist
);

  localparam int NW = HIST_LEN + 1;                 // weights per perceptron
  localparam int IW = $clog2(NUM_PERC);
  localparam int JW = $clog2(NW);
  localparam int SW = $clog2(NW + 1);               // step also reaches NW
  localparam int AW = WEIGHT_W + JW + 1;            // NW weights can't overflow
  localparam int XW = (ADDR_W > HIST_LEN) ? ADDR_W : HIST_LEN;

  localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SUM, S_WAIT_UPD, S_TRAIN} state_t;
  state_t state, state_nxt;

  // Weight table; entry [p][0] is the bias of perceptron p.
  logic [NUM_PERC-1:0][HIST_LEN:0][WEIGHT_W-1:0] w;

  logic [IW-1:0]        clr_cnt;
  logic [SW-1:0]        step;
  logic [IW-1:0]        idx;
  logic [HIST_LEN-1:0]  snap;
  logic signed [AW-1:0] acc;
  logic                 pt_q, pc_q, upd_t_q;
  logic [HIST_LEN-1:0]  hist_q;

  logic [XW-1:0]          key;
  logic [IW-1:0]          idx_nxt;
  logic [JW-1:0]          j;
  logic [NW-1:0]          xvec;
  logic                   xbit;
  logic signed [WEIGHT_W-1:0] wsel, w_trn;
  logic signed [AW-1:0]   wext, acc_nxt;
  logic                   sum_fin, trn_fin, last_clr;

  // ---------------- index ----------------
  always_comb begin
`ifdef BP_HIST_HASH_EN
    key = XW'(req_addr >> 2) ^ XW'(hist_q);
`else
    key = XW'(req_addr >> 2);
`endif
  end
  assign idx_nxt = IW'(key % XW'(NUM_PERC));

  // ---------------- datapath ----------------
  assign j       = step[JW-1:0];
  assign xvec    = {snap, 1'b1};                    // x0 is the constant bias input
  assign xbit    = xvec[j];
  assign wsel    = w[idx][j];
  assign wext    = {{(AW-WEIGHT_W){wsel[WEIGHT_W-1]}}, wsel};
  assign acc_nxt = xbit ? (acc + wext) : (acc - wext);

  assign last_clr = (clr_cnt == IW'(NUM_PERC - 1));
  assign sum_fin  = (step == SW'(NW));              // extra cycle that presents the result
  assign trn_fin  = (step == SW'(HIST_LEN));

  // t*x is +1 exactly when outcome and input agree; saturate at both ends.
  always_comb begin
    w_trn = wsel;
    if (upd_t_q == xbit) begin
      if (wsel != W_MAX) w_trn = wsel + 1'b1;
    end else begin
      if (wsel != W_MIN) w_trn = wsel - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      step    <= '0;
      idx     <= '0;
      snap    <= '0;
      acc     <= '0;
      pt_q    <= 1'b0;
      pc_q    <= 1'b0;
      upd_t_q <= 1'b0;
      hist_q  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          w[clr_cnt] <= '0;
          clr_cnt    <= clr_cnt + 1'b1;
        end
        S_IDLE: if (req_valid) begin
          idx  <= idx_nxt;
          snap <= hist_q;
          acc  <= '0;
          step <= '0;
        end
        S_SUM: begin
          if (sum_fin) begin
            step <= '0;
          end else begin
            step <= step + 1'b1;
            acc  <= acc_nxt;
            if (step == SW'(HIST_LEN)) begin
              pt_q <= ~acc_nxt[AW-1];
              pc_q <= (int'(acc_nxt) > THETA) || (int'(acc_nxt) < -THETA);
            end
          end
        end
        S_WAIT_UPD: if (upd_valid) begin
          hist_q  <= {hist_q[HIST_LEN-2:0], upd_taken};
          upd_t_q <= upd_taken;
          step    <= '0;
        end
        S_TRAIN: begin
          w[idx][j] <= w_trn;
          step      <= trn_fin ? '0 : step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:    if (last_clr)  state_nxt = S_IDLE;
      S_IDLE:     if (req_valid) state_nxt = S_SUM;
      S_SUM:      if (sum_fin)   state_nxt = S_WAIT_UPD;
      S_WAIT_UPD: if (upd_valid)
                    state_nxt = ((pt_q != upd_taken) || !pc_q) ? S_TRAIN : S_IDLE;
      S_TRAIN:    if (trn_fin)   state_nxt = S_IDLE;
      default:                   state_nxt = S_CLEAR;
    endcase
  end

  // Outputs are forced to their reset values while rst_n is low, even
  // before the first clock edge has moved the FSM into CLEAR.
  always_comb begin
    req_ready  = 1'b0;
    upd_ready  = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    pred_conf  = 1'b0;
    busy       = 1'b1;
    hist       = '0;
    if (rst_n) begin
      req_ready  = (state == S_IDLE);
      upd_ready  = (state == S_WAIT_UPD);
      pred_valid = (state == S_SUM) && sum_fin;
      pred_taken = pt_q;
      pred_conf  = pc_q;
      busy       = (state != S_IDLE);
      hist       = hist_q;
    end
  end

endmodule

// File: doc/perceptron_bp.md
PERCEPTRON_BP -- requirements
Module: perceptron_bp

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction address width.
REQ-002 Parameter HIST_LEN, default 7, SHALL set the global history length in bits (legal range 2..15).
REQ-003 Parameter WEIGHT_W, default 8, SHALL set the signed two's-complement weight width (legal range 2..8).
REQ-004 Parameter NUM_PERC, default 12, SHALL set the number of perceptrons (legal range 2..64).
REQ-005 Parameter THETA, default 15, SHALL set the training threshold.
REQ-006 Port clk, input, 1 bit, SHALL be the clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-008 Port req_valid, input, 1 bit, SHALL request a prediction.
REQ-009 Port req_ready, output, 1 bit, SHALL indicate that a request is accepted this cycle.
REQ-010 Port req_addr, input, ADDR_W bits, SHALL carry the branch instruction address.
REQ-011 Port pred_valid, output, 1 bit, SHALL be a one-cycle pulse qualifying pred_taken and pred_conf.
REQ-012 Port pred_taken, output, 1 bit, SHALL give the predicted direction (1 = taken).
REQ-013 Port pred_conf, output, 1 bit, SHALL be 1 when |sum| > THETA.
REQ-014 Port upd_valid, input, 1 bit, SHALL deliver the resolved outcome of the last predicted branch.
REQ-015 Port upd_ready, output, 1 bit, SHALL indicate that an outcome is accepted this cycle.
REQ-016 Port upd_taken, input, 1 bit, SHALL carry the resolved direction.
REQ-017 Port busy, output, 1 bit, SHALL be 1 whenever the FSM is not in IDLE.
REQ-018 Port hist, output, HIST_LEN bits, SHALL expose the global history register; bit 0 is the newest outcome.

Function
REQ-019 Storage SHALL be internal registers holding NUM_PERC x (HIST_LEN+1) weights; weight 0 of each perceptron is the bias.
REQ-020 The FSM SHALL have exactly the states CLEAR, IDLE, SUM, WAIT_UPD and TRAIN.
REQ-021 CLEAR SHALL zero one perceptron per cycle for NUM_PERC cycles, then go to IDLE; req_ready and upd_ready SHALL be 0 throughout.
REQ-022 IDLE SHALL drive req_ready=1; on req_valid&req_ready it SHALL latch the index (req_addr>>2) mod NUM_PERC, snapshot hist, and go to SUM.
REQ-023 SUM SHALL accumulate one weight per cycle for HIST_LEN+1 cycles: w0 always added; wj (j>=1) added if snapshot bit j-1 is 1, else subtracted.
REQ-024 The accumulator SHALL be WEIGHT_W+$clog2(HIST_LEN+1)+1 bits wide and SHALL never overflow.
REQ-025 pred_valid SHALL pulse exactly HIST_LEN+2 cycles after the accept cycle (9 with defaults), with pred_taken = (sum >= 0); the FSM SHALL then enter WAIT_UPD.
REQ-026 pred_taken and pred_conf SHALL hold their values until the next pred_valid.
REQ-027 WAIT_UPD SHALL drive upd_ready=1 and req_ready=0; on handshake, hist SHALL shift left with upd_taken entering bit 0.
REQ-028 On that handshake the FSM SHALL go to TRAIN if pred_taken != upd_taken or |sum| <= THETA, else to IDLE.
REQ-029 TRAIN SHALL update one weight per cycle for HIST_LEN+1 cycles using the snapshot history: wj += t*xj, with t=+1 if taken else -1, x0=+1, and xj=+1 if the snapshot bit is 1 else -1; it SHALL then go to IDLE.
REQ-030 Weight updates SHALL saturate at -2^(WEIGHT_W-1) and 2^(WEIGHT_W-1)-1.
REQ-031 upd_valid outside WAIT_UPD and req_valid outside IDLE SHALL be ignored with no state change.

Reset
REQ-032 While rst_n=0 the block SHALL drive: req_ready=0, upd_ready=0, pred_valid=0, pred_taken=0, pred_conf=0, hist=0, busy=1; the FSM SHALL be in CLEAR with the clear counter at 0.
REQ-033 Reset asserted in any state, including mid-SUM or mid-TRAIN, SHALL abort the operation and re-run the full CLEAR.

Configuration
REQ-034 With macro BP_HIST_HASH_EN defined, the index SHALL be ((req_addr>>2) XOR zero-extended hist) mod NUM_PERC; without it, the index SHALL be (req_addr>>2) mod NUM_PERC.

Verification
REQ-035 Release reset -> busy=1 for 12 cycles, then req_ready=1; request addr 0x10 -> pred_taken=1, pred_conf=0.
REQ-036 Accept at cycle T -> pred_valid pulses only at T+9; upd_valid held high before T+10 -> hist unchanged.
REQ-037 From reset, predict addr 0x10, update taken -> TRAIN runs 8 cycles; perceptron 4 becomes w0=+1, w1..w7=-1; hist=0000001.
REQ-038 WEIGHT_W=2, same branch updated not-taken 4 times with hist=0 -> w0 saturates at -2 and does not wrap.
REQ-039 Reset asserted mid-TRAIN -> CLEAR reruns; hist=0; next prediction matches the fresh-reset result.
REQ-040 BP_HIST_HASH_EN defined, hist=0000011, addr 0x10 -> index 7; undefined -> index 4.
